// File: rtl/float_div_arbiter.sv
// Round-robin arbiter that shares one combinational float_divider among NUM_REQ requesters.
// Optional build macro FDIV_ARB_ZERO_CHECK_EN: zero divisors bypass the divider and raise resp_dbz.

module float_divider #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127
) (
    input  logic [FLOAT_SIZE-1:0] a,
    input  logic [FLOAT_SIZE-1:0] b,
    output logic [FLOAT_SIZE-1:0] out,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int QW = MANTISSA_SIZE + 3;
    localparam int RW = MANTISSA_SIZE + 2;
    localparam int EW = EXPONENT_SIZE + 2;

    logic                     sign_s;
    logic [EXPONENT_SIZE-1:0] exp_a_s;
    logic [EXPONENT_SIZE-1:0] exp_b_s;
    logic [MANTISSA_SIZE:0]   man_a_s;
    logic [MANTISSA_SIZE:0]   man_b_s;
    logic                     a_zero_s;
    logic                     b_zero_s;
    logic                     a_inf_s;
    logic                     b_inf_s;
    logic [QW-1:0]            quot_s;
    logic [RW-1:0]            rem_s;
    logic [MANTISSA_SIZE-1:0] frac_trunc_s;
    logic                     guard_s;
    logic                     sticky_s;
    logic                     round_up_s;
    logic                     norm_adj_s;
    logic [MANTISSA_SIZE:0]   frac_rnd_s;
    logic [EW-1:0]            exp_res_s;
    logic [FLOAT_SIZE-1:0]    zero_res_s;
    logic [FLOAT_SIZE-1:0]    inf_res_s;

    // Denormals are flushed to zero; an all-ones exponent is treated as infinity.
    assign sign_s     = a[FLOAT_SIZE-1] ^ b[FLOAT_SIZE-1];
    assign exp_a_s    = a[FLOAT_SIZE-2:MANTISSA_SIZE];
    assign exp_b_s    = b[FLOAT_SIZE-2:MANTISSA_SIZE];
    assign man_a_s    = {1'b1, a[MANTISSA_SIZE-1:0]};
    assign man_b_s    = {1'b1, b[MANTISSA_SIZE-1:0]};
    assign a_zero_s   = (exp_a_s == {EXPONENT_SIZE{1'b0}});
    assign b_zero_s   = (exp_b_s == {EXPONENT_SIZE{1'b0}});
    assign a_inf_s    = (exp_a_s == {EXPONENT_SIZE{1'b1}});
    assign b_inf_s    = (exp_b_s == {EXPONENT_SIZE{1'b1}});
    assign zero_res_s = {sign_s, {(FLOAT_SIZE-1){1'b0}}};
    assign inf_res_s  = {sign_s, {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};

    // Restoring mantissa division, integer quotient bit first.
    always_comb begin
        rem_s  = {1'b0, man_a_s};
        quot_s = {QW{1'b0}};
        for (int i = QW - 1; i >= 0; i--) begin
            if (rem_s >= {1'b0, man_b_s}) begin
                quot_s[i] = 1'b1;
                rem_s     = rem_s - {1'b0, man_b_s};
            end else begin
                quot_s[i] = 1'b0;
            end
            rem_s = {rem_s[RW-2:0], 1'b0};
        end
    end

    // Mantissa ratio lies in (0.5, 2): normalise, then round to nearest even.
    always_comb begin
        norm_adj_s = ~quot_s[QW-1];
        if (quot_s[QW-1]) begin
            frac_trunc_s = quot_s[QW-2:2];
            guard_s      = quot_s[1];
            sticky_s     = quot_s[0] | (|rem_s);
        end else begin
            frac_trunc_s = quot_s[QW-3:1];
            guard_s      = quot_s[0];
            sticky_s     = |rem_s;
        end
        round_up_s = guard_s & (sticky_s | frac_trunc_s[0]);
        frac_rnd_s = {1'b0, frac_trunc_s} + {{MANTISSA_SIZE{1'b0}}, round_up_s};
        exp_res_s  = {2'b00, exp_a_s} + EW'(BIAS) - {2'b00, exp_b_s}
                   - {{(EW-1){1'b0}}, norm_adj_s} + {{(EW-1){1'b0}}, frac_rnd_s[MANTISSA_SIZE]};
    end

    // Special operands first, then range checks on the biased result exponent.
    always_comb begin
        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_zero_s || b_inf_s) begin
            out = zero_res_s;
        end else if (a_inf_s) begin
            out = inf_res_s;
        end else if (b_zero_s) begin
            out      = inf_res_s;
            overflow = 1'b1;
        end else if (exp_res_s[EW-1] || (exp_res_s == {EW{1'b0}})) begin
            out       = zero_res_s;
            underflow = 1'b1;
        end else if (exp_res_s >= {2'b00, {EXPONENT_SIZE{1'b1}}}) begin
            out      = inf_res_s;
            overflow = 1'b1;
        end else begin
            out = {sign_s, exp_res_s[EXPONENT_SIZE-1:0], frac_rnd_s[MANTISSA_SIZE-1:0]};
        end
    end
endmodule

module float_div_arbiter #(
    parameter int FLOAT_SIZE    = 32,
    parameter int EXPONENT_SIZE = 8,
    parameter int MANTISSA_SIZE = 23,
    parameter int BIAS          = 127,
    parameter int NUM_REQ       = 4,
    localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_a,
    input  logic [NUM_REQ*FLOAT_SIZE-1:0] req_b,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [ID_W-1:0]               resp_id,
    output logic [FLOAT_SIZE-1:0]         resp_out,
    output logic [1:0]                    resp_flags,
    output logic                          resp_dbz
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_r;
    logic [ID_W-1:0]       ptr_r;
    logic [FLOAT_SIZE-1:0] op_a_r;
    logic [FLOAT_SIZE-1:0] op_b_r;
    logic [ID_W-1:0]       op_id_r;
    logic                  resp_valid_r;
    logic [ID_W-1:0]       resp_id_r;
    logic [FLOAT_SIZE-1:0] resp_out_r;
    logic [1:0]            resp_flags_r;
    logic                  resp_dbz_r;

    logic [NUM_REQ-1:0]    upper_mask_s;
    logic [ID_W:0]         hit_hi_s;
    logic [ID_W:0]         hit_all_s;
    logic [ID_W:0]         pick_s;
    logic                  grant_vld_s;
    logic [ID_W-1:0]       grant_idx_s;
    logic [ID_W-1:0]       next_ptr_s;
    logic [FLOAT_SIZE-1:0] sel_a_s;
    logic [FLOAT_SIZE-1:0] sel_b_s;
    logic [FLOAT_SIZE-1:0] div_out_s;
    logic                  div_ovf_s;
    logic                  div_unf_s;
    logic [FLOAT_SIZE-1:0] result_s;
    logic [1:0]            result_flags_s;
    logic                  result_dbz_s;

    // Lowest set bit wins; MSB of the result says whether any bit was set.
    function automatic logic [ID_W:0] first_set(input logic [NUM_REQ-1:0] vec);
        logic [ID_W:0] res;
        res = {(ID_W+1){1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, ID_W'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Requesters at or above the pointer get first pick, then the search wraps.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            upper_mask_s[i] = (ID_W'(i) >= ptr_r);
        end
    end

    assign hit_hi_s    = first_set(req_valid & upper_mask_s);
    assign hit_all_s   = first_set(req_valid);
    assign pick_s      = hit_hi_s[ID_W] ? hit_hi_s : hit_all_s;
    assign grant_vld_s = pick_s[ID_W] && (state_r == ST_IDLE) && !reset;
    assign grant_idx_s = pick_s[ID_W-1:0];
    assign next_ptr_s  = (grant_idx_s == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                             : grant_idx_s + ID_W'(1'b1);

    // One-hot accept and AND-OR operand selection for the granted requester.
    always_comb begin
        sel_a_s = {FLOAT_SIZE{1'b0}};
        sel_b_s = {FLOAT_SIZE{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_vld_s && (grant_idx_s == ID_W'(i));
            sel_a_s = sel_a_s | (req_a[i*FLOAT_SIZE +: FLOAT_SIZE] & {FLOAT_SIZE{grant_idx_s == ID_W'(i)}});
            sel_b_s = sel_b_s | (req_b[i*FLOAT_SIZE +: FLOAT_SIZE] & {FLOAT_SIZE{grant_idx_s == ID_W'(i)}});
        end
    end

    float_divider #(
        .FLOAT_SIZE    (FLOAT_SIZE),
        .EXPONENT_SIZE (EXPONENT_SIZE),
        .MANTISSA_SIZE (MANTISSA_SIZE),
        .BIAS          (BIAS)
    ) u_div (
        .a         (op_a_r),
        .b         (op_b_r),
        .out       (div_out_s),
        .overflow  (div_ovf_s),
        .underflow (div_unf_s)
    );

`ifdef FDIV_ARB_ZERO_CHECK_EN
    // A signed-zero divisor yields a signed infinity with only the dbz flag raised.
    always_comb begin
        if (op_b_r[FLOAT_SIZE-2:0] == {(FLOAT_SIZE-1){1'b0}}) begin
            result_s       = {op_a_r[FLOAT_SIZE-1] ^ op_b_r[FLOAT_SIZE-1],
                              {EXPONENT_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
            result_flags_s = 2'b00;
            result_dbz_s   = 1'b1;
        end else begin
            result_s       = div_out_s;
            result_flags_s = {div_ovf_s, div_unf_s};
            result_dbz_s   = 1'b0;
        end
    end
`else
    // Divider output is always used; no zero-divisor detection.
    always_comb begin
        result_s       = div_out_s;
        result_flags_s = {div_ovf_s, div_unf_s};
        result_dbz_s   = 1'b0;
    end
`endif

    // IDLE -> BUSY on grant, BUSY -> DONE registering the result, DONE -> IDLE on consume.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            ptr_r        <= {ID_W{1'b0}};
            op_a_r       <= {FLOAT_SIZE{1'b0}};
            op_b_r       <= {FLOAT_SIZE{1'b0}};
            op_id_r      <= {ID_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_id_r    <= {ID_W{1'b0}};
            resp_out_r   <= {FLOAT_SIZE{1'b0}};
            resp_flags_r <= 2'b00;
            resp_dbz_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_vld_s) begin
                        op_a_r  <= sel_a_s;
                        op_b_r  <= sel_b_s;
                        op_id_r <= grant_idx_s;
                        ptr_r   <= next_ptr_s;
                        state_r <= ST_BUSY;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    resp_out_r   <= result_s;
                    resp_flags_r <= result_flags_s;
                    resp_dbz_r   <= result_dbz_s;
                    resp_id_r    <= op_id_r;
                    resp_valid_r <= 1'b1;
                    state_r      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
            endcase
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_out   = resp_out_r;
    assign resp_flags = resp_flags_r;
    assign resp_dbz   = resp_dbz_r;
endmodule
